serial_frame_demux: RTL and testbench

Parametrised serial frame receiver that generalises the team's single-port serial transmitter controller into a complete multi-channel demultiplexer with datapath. It decodes frames on a one-bit serial line and routes each payload bit to one of NUM_CH output channels. A frame is a start bit, a port field, a length field, then a variable-length payload. The block sits between the serial line sampler and the per-channel consumers. It adds several features the previous generation lacked:
- parametrised field widths and channel count
- zero-length frames
- bad-port detection
- a busy indication

---
 rtl/serial_frame_demux_if.sv | 46 ++++
 rtl/serial_frame_demux.sv | 167 ++++++++++++++++
 tb/tb_serial_frame_demux.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_demux_if.sv
// serial_frame_demux_if
//   Bundles the serial input side and the demultiplexed output side of
//   serial_frame_demux.
//
//   master : the environment driving the serial line (clkEn, SerIn) and
//            observing the decoded outputs.
//   slave  : the demux itself.
//
//   Signals
//     clkEn     bit-slot enable; the demux only advances when it is high
//     SerIn     serial line, idles high
//     SerOut    registered payload bit, holds between payload bits
//     OutValid  one-hot per-channel qualifier for SerOut, one clk per bit
//     PortOut   port field of the current / last frame
//     Done      one clk pulse on the edge that enters the stop slot
//     BadPort   one clk pulse when the port field is >= NUM_CH
//     Busy      high whenever the decoder is not idle
//     state_dbg raw decoder state, for observation only
//
//   Flow control: there is no backpressure. OutValid is a pure qualifier;
//   a consumer must take SerOut in the clk cycle its OutValid bit is high,
//   because the bit is never re-presented.
interface serial_frame_demux_if #(
  parameter int NUM_CH = 4,
  parameter int PORT_W = 2
);
  logic              clkEn;
  logic              SerIn;
  logic              SerOut;
  logic [NUM_CH-1:0] OutValid;
  logic [PORT_W-1:0] PortOut;
  logic              Done;
  logic              BadPort;
  logic              Busy;
  logic [2:0]        state_dbg;

  modport master (
    output clkEn, SerIn,
    input  SerOut, OutValid, PortOut, Done, BadPort, Busy, state_dbg
  );

  modport slave (
    input  clkEn, SerIn,
    output SerOut, OutValid, PortOut, Done, BadPort, Busy, state_dbg
  );
endinterface

// File: rtl/serial_frame_demux.sv
// serial_frame_demux
//   Decodes frames on a one-bit serial line and routes each payload bit to
//   one of NUM_CH channels. Frame layout, one bit per enabled slot:
//     start(0) | port[PORT_W] MSB first | len[LEN_W] MSB first |
//     payload[len] | stop (ignored)
//
//   Ports
//     clk  rising-edge system clock
//     rst  asynchronous active-low reset
//     bus  serial_frame_demux_if.slave (see the interface for signal list)
//
//   Only clk edges with clkEn=1 advance state, counters and sampling. The
//   pulse outputs (OutValid, Done, BadPort) are cleared on every clk edge,
//   so each pulse lasts one clk cycle whatever the clkEn density.
module serial_frame_demux #(
  parameter int NUM_CH = 4,
  parameter int PORT_W = 2,
  parameter int LEN_W  = 4
) (
  input logic clk,
  input logic rst,
  serial_frame_demux_if.slave bus
);

  localparam int CW = (PORT_W > LEN_W) ? PORT_W : LEN_W;
  localparam logic [CW-1:0]   PORT_LAST = CW'(PORT_W - 1);
  localparam logic [CW-1:0]   LEN_LAST  = CW'(LEN_W - 1);
  // NUM_CH can be as large as 2^PORT_W, so it needs one extra bit.
  localparam logic [PORT_W:0] NUM_CH_W  = (PORT_W + 1)'(NUM_CH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PORT = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    STOP = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PORT_W-1:0] port_q, port_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ser_q, ser_d;
  logic [NUM_CH-1:0] valid_q, valid_d;
  logic [PORT_W-1:0] portout_q, portout_d;
  logic              done_q, done_d;
  logic              bad_q, bad_d;

  // Shift-in values: the size cast drops the oldest bit, keeping the
  // field MSB first.
  logic [PORT_W-1:0] port_sh;
  logic [LEN_W-1:0]  len_sh;
  logic [LEN_W-1:0]  len_m1;
  logic [NUM_CH-1:0] onehot;
  logic              port_ok;

  assign port_sh = PORT_W'({port_q, bus.SerIn});
  assign len_sh  = LEN_W'({len_q, bus.SerIn});
  assign len_m1  = len_q - LEN_W'(1);
  assign onehot  = NUM_CH'(1) << port_q;
  assign port_ok = ({1'b0, port_q} < NUM_CH_W);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    port_d    = port_q;
    len_d     = len_q;
    ser_d     = ser_q;
    portout_d = portout_q;
    valid_d   = '0;
    done_d    = 1'b0;
    bad_d     = 1'b0;

    if (bus.clkEn) begin
      case (state_q)
        IDLE: begin
          if (!bus.SerIn) begin
            state_d = PORT;
            cnt_d   = '0;
          end
        end

        PORT: begin
          port_d = port_sh;
          if (cnt_q == PORT_LAST) begin
            state_d   = LEN;
            cnt_d     = '0;
            portout_d = port_sh;
            bad_d     = ({1'b0, port_sh} >= NUM_CH_W);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        LEN: begin
          len_d = len_sh;
          if (cnt_q == LEN_LAST) begin
            cnt_d = '0;
            if (len_sh != '0) begin
              state_d = DATA;
            end else begin
              state_d = STOP;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        DATA: begin
          // Bits for an out-of-range port are consumed but never qualified.
          ser_d   = bus.SerIn;
          valid_d = port_ok ? onehot : '0;
          if (cnt_q == CW'(len_m1)) begin
            state_d = STOP;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        STOP: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      port_q    <= '0;
      len_q     <= '0;
      ser_q     <= 1'b0;
      valid_q   <= '0;
      portout_q <= '0;
      done_q    <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      port_q    <= port_d;
      len_q     <= len_d;
      ser_q     <= ser_d;
      valid_q   <= valid_d;
      portout_q <= portout_d;
      done_q    <= done_d;
      bad_q     <= bad_d;
    end
  end

  assign bus.SerOut    = ser_q;
  assign bus.OutValid  = valid_q;
  assign bus.PortOut   = portout_q;
  assign bus.Done      = done_q;
  assign bus.BadPort   = bad_q;
  assign bus.Busy      = (state_q != IDLE);
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_serial_frame_demux.sv
module tb_serial_frame_demux;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_frame_demux_if #(.NUM_CH(4), .PORT_W(2)) bus4 ();
  serial_frame_demux_if #(.NUM_CH(3), .PORT_W(2)) bus3 ();

  serial_frame_demux #(.NUM_CH(4), .PORT_W(2), .LEN_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  serial_frame_demux #(.NUM_CH(3), .PORT_W(2), .LEN_W(4)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  int errors = 0;
  int checks = 0;

  // Frame 0|10|0011|101 used by several scenarios.
  logic [9:0] f_basic = 10'b0_10_0011_101;

  // ---------------- driver ----------------
  // Drive on the falling edge, let one rising edge happen, sample 1 time
  // unit later. Both DUTs share clkEn; each gets its own serial bit.
  task automatic step(input logic en, input logic b4, input logic b3);
    @(negedge clk);
    bus4.clkEn = en;
    bus4.SerIn = b4;
    bus3.clkEn = en;
    bus3.SerIn = b3;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step(1'b1, 1'b1, 1'b1);
    checks++; if (bus4.SerOut !== 1'b0) begin errors++; $display("FAIL reset_serout got %b want 0", bus4.SerOut); end
    checks++; if (bus4.OutValid !== 4'b0000) begin errors++; $display("FAIL reset_outvalid got %b want 0000", bus4.OutValid); end
    checks++; if (bus4.PortOut !== 2'b00) begin errors++; $display("FAIL reset_portout got %b want 00", bus4.PortOut); end
    checks++; if (bus4.Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus4.Done); end
    checks++; if (bus4.BadPort !== 1'b0) begin errors++; $display("FAIL reset_badport got %b want 0", bus4.BadPort); end
    checks++; if (bus4.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus4.Busy); end
    checks++; if (bus4.state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus4.state_dbg); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic b;
    logic [3:0] ov_exp;
    for (int i = 0; i < 13; i++) begin
      b = (i < 10) ? f_basic[9-i] : 1'b1;
      step(1'b1, b, 1'b1);
      ov_exp = (i >= 7 && i <= 9) ? 4'b0100 : 4'b0000;
      checks++; if (bus4.OutValid !== ov_exp) begin errors++; $display("FAIL basic_outvalid E%0d got %b want %b", i, bus4.OutValid, ov_exp); end
      checks++; if (bus4.Done !== (i == 9)) begin errors++; $display("FAIL basic_done E%0d got %b want %b", i, bus4.Done, (i == 9)); end
      checks++; if (bus4.Busy !== (i <= 9)) begin errors++; $display("FAIL basic_busy E%0d got %b want %b", i, bus4.Busy, (i <= 9)); end
      if (i >= 7 && i <= 9) begin
        checks++; if (bus4.SerOut !== f_basic[9-i]) begin errors++; $display("FAIL basic_serout E%0d got %b want %b", i, bus4.SerOut, f_basic[9-i]); end
      end
      if (i >= 2) begin
        checks++; if (bus4.PortOut !== 2'd2) begin errors++; $display("FAIL basic_portout E%0d got %0d want 2", i, bus4.PortOut); end
      end
    end
  endtask

  task automatic test_zero_len();
    logic [6:0] f = 7'b0_01_0000;
    logic b;
    for (int i = 0; i < 9; i++) begin
      b = (i < 7) ? f[6-i] : 1'b1;
      step(1'b1, b, 1'b1);
      checks++; if (bus4.OutValid !== 4'b0000) begin errors++; $display("FAIL zero_outvalid E%0d got %b want 0000", i, bus4.OutValid); end
      checks++; if (bus4.Done !== (i == 6)) begin errors++; $display("FAIL zero_done E%0d got %b want %b", i, bus4.Done, (i == 6)); end
      checks++; if (bus4.Busy !== (i <= 6)) begin errors++; $display("FAIL zero_busy E%0d got %b want %b", i, bus4.Busy, (i <= 6)); end
      if (i == 2) begin
        checks++; if (bus4.PortOut !== 2'd1) begin errors++; $display("FAIL zero_portout got %0d want 1", bus4.PortOut); end
      end
    end
  endtask

  task automatic test_bad_port();
    logic [8:0] f = 9'b0_11_0010_11;
    logic b;
    for (int i = 0; i < 11; i++) begin
      b = (i < 9) ? f[8-i] : 1'b1;
      step(1'b1, 1'b1, b);
      checks++; if (bus3.BadPort !== (i == 2)) begin errors++; $display("FAIL bad_badport E%0d got %b want %b", i, bus3.BadPort, (i == 2)); end
      checks++; if (bus3.OutValid !== 3'b000) begin errors++; $display("FAIL bad_outvalid E%0d got %b want 000", i, bus3.OutValid); end
      checks++; if (bus3.Done !== (i == 8)) begin errors++; $display("FAIL bad_done E%0d got %b want %b", i, bus3.Done, (i == 8)); end
      checks++; if (bus3.Busy !== (i <= 8)) begin errors++; $display("FAIL bad_busy E%0d got %b want %b", i, bus3.Busy, (i <= 8)); end
      if (i == 2) begin
        checks++; if (bus3.PortOut !== 2'd3) begin errors++; $display("FAIL bad_portout got %0d want 3", bus3.PortOut); end
      end
    end
  endtask

  task automatic test_sparse_en();
    logic b;
    logic en;
    logic [3:0] ov_exp;
    int pulses = 0;
    for (int i = 0; i < 13; i++) begin
      b = (i < 10) ? f_basic[9-i] : 1'b1;
      for (int c = 0; c < 3; c++) begin
        en = (c == 0);
        step(en, b, 1'b1);
        ov_exp = (en && i >= 7 && i <= 9) ? 4'b0100 : 4'b0000;
        checks++; if (bus4.OutValid !== ov_exp) begin errors++; $display("FAIL sparse_outvalid slot%0d c%0d got %b want %b", i, c, bus4.OutValid, ov_exp); end
        checks++; if (bus4.Done !== (en && i == 9)) begin errors++; $display("FAIL sparse_done slot%0d c%0d got %b want %b", i, c, bus4.Done, (en && i == 9)); end
        if (i >= 7 && i <= 9) begin
          checks++; if (bus4.SerOut !== f_basic[9-i]) begin errors++; $display("FAIL sparse_serout slot%0d c%0d got %b want %b", i, c, bus4.SerOut, f_basic[9-i]); end
        end
        if (bus4.OutValid != 4'b0000) pulses++;
      end
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL sparse_pulse_count got %0d want 3", pulses); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] f = 8'b0_00_0001_1;
    logic b;
    int pulses = 0;
    for (int i = 0; i < 9; i++) step(1'b1, f_basic[9-i], 1'b1);
    // Assert reset between clock edges to prove it is asynchronous.
    #2 rst = 1'b0;
    #1;
    checks++; if (bus4.OutValid !== 4'b0000) begin errors++; $display("FAIL midrst_outvalid got %b want 0000", bus4.OutValid); end
    checks++; if (bus4.PortOut !== 2'b00) begin errors++; $display("FAIL midrst_portout got %b want 00", bus4.PortOut); end
    checks++; if (bus4.Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus4.Busy); end
    checks++; if (bus4.SerOut !== 1'b0) begin errors++; $display("FAIL midrst_serout got %b want 0", bus4.SerOut); end
    checks++; if (bus4.Done !== 1'b0 || bus4.BadPort !== 1'b0) begin errors++; $display("FAIL midrst_pulses got done=%b bad=%b want 0 0", bus4.Done, bus4.BadPort); end
    step(1'b1, 1'b0, 1'b1);
    checks++; if (bus4.Busy !== 1'b0) begin errors++; $display("FAIL midrst_held_busy got %b want 0", bus4.Busy); end
    @(negedge clk);
    bus4.SerIn = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b = (i < 8) ? f[7-i] : 1'b1;
      step(1'b1, b, 1'b1);
      checks++; if (bus4.OutValid !== ((i == 7) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL midrst_frame_outvalid E%0d got %b want %b", i, bus4.OutValid, ((i == 7) ? 4'b0001 : 4'b0000)); end
      checks++; if (bus4.Done !== (i == 7)) begin errors++; $display("FAIL midrst_frame_done E%0d got %b want %b", i, bus4.Done, (i == 7)); end
      checks++; if (bus4.Busy !== (i <= 7)) begin errors++; $display("FAIL midrst_frame_busy E%0d got %b want %b", i, bus4.Busy, (i <= 7)); end
      if (i == 7) begin
        checks++; if (bus4.SerOut !== 1'b1) begin errors++; $display("FAIL midrst_frame_serout got %b want 1", bus4.SerOut); end
      end
      if (bus4.OutValid != 4'b0000) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL midrst_pulse_count got %0d want 1", pulses); end
  endtask

  task automatic test_back_to_back();
    // 0|01|0001|1|stop then immediately 0|10|0001|0|stop
    logic [17:0] v = 18'b001000111_010000101;
    logic b;
    logic [3:0] ov_exp;
    int first = -1;
    int second = -1;
    int ndone = 0;
    for (int i = 0; i < 20; i++) begin
      b = (i < 18) ? v[17-i] : 1'b1;
      step(1'b1, b, 1'b1);
      ov_exp = (i == 7) ? 4'b0010 : ((i == 16) ? 4'b0100 : 4'b0000);
      checks++; if (bus4.OutValid !== ov_exp) begin errors++; $display("FAIL b2b_outvalid E%0d got %b want %b", i, bus4.OutValid, ov_exp); end
      if (i == 7) begin
        checks++; if (bus4.SerOut !== 1'b1) begin errors++; $display("FAIL b2b_serout1 got %b want 1", bus4.SerOut); end
      end
      if (i == 16) begin
        checks++; if (bus4.SerOut !== 1'b0) begin errors++; $display("FAIL b2b_serout2 got %b want 0", bus4.SerOut); end
      end
      if (bus4.Done === 1'b1) begin
        ndone++;
        if (first < 0) first = i;
        else second = i;
      end
    end
    checks++; if (ndone != 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", ndone); end
    checks++; if (first != 7) begin errors++; $display("FAIL b2b_first_done got E%0d want E7", first); end
    checks++; if (second - first != 9) begin errors++; $display("FAIL b2b_done_spacing got %0d want 9", second - first); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus4.clkEn = 1'b0;
    bus4.SerIn = 1'b1;
    bus3.clkEn = 1'b0;
    bus3.SerIn = 1'b1;
    test_reset();
    test_basic();
    test_zero_len();
    test_bad_port();
    test_sparse_en();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
